// File: rtl/path_pkg.sv
// Shared types for the direction-stack path logic: move encoding, drain FSM states, stack depth.
package path_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  localparam int STACK_DEPTH = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_PRESENT,
    ST_POP,
    ST_DONE
  } drain_state_t;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_RIGHT: return DIR_LEFT;
      DIR_DOWN:  return DIR_UP;
      default:   return DIR_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/path_drain_if.sv
// Stack-side and move-stream signals of the path drainer; master is the drainer itself.
interface path_drain_if;
  import path_pkg::*;

  logic stk_empty;
  dir_t stk_top;
  logic stk_pop;
  logic out_valid;
  logic out_ready;
  dir_t out_dir;

  modport master (
    input  stk_empty, stk_top, out_ready,
    output stk_pop, out_valid, out_dir
  );

  modport slave (
    output stk_empty, stk_top, out_ready,
    input  stk_pop, out_valid, out_dir
  );

endinterface

// File: rtl/path_drain.sv
// Pops the direction stack newest-first and streams each entry (optionally reversed) as a move.
// Every output is registered; hold tells upstream to stop pushing for the whole drain.
module path_drain
  import path_pkg::*;
#(
  parameter bit INVERT     = 1'b1,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  path_drain_if.master     bus,
  output logic             hold,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam int SW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  drain_state_t     state, nxt_state;
  logic [SW-1:0]    settle_cnt, nxt_settle;
  logic             nxt_pop, nxt_valid, nxt_hold, nxt_done;
  dir_t             nxt_dir;
  logic [CNT_W-1:0] nxt_count;
  logic             handshake;

  assign handshake = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      settle_cnt    <= '0;
      bus.stk_pop   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_dir   <= DIR_UP;
      hold          <= 1'b0;
      done          <= 1'b0;
      count         <= '0;
    end else begin
      state         <= nxt_state;
      settle_cnt    <= nxt_settle;
      bus.stk_pop   <= nxt_pop;
      bus.out_valid <= nxt_valid;
      bus.out_dir   <= nxt_dir;
      hold          <= nxt_hold;
      done          <= nxt_done;
      count         <= nxt_count;
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE:    if (start) nxt_state = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == '0) nxt_state = ST_CHECK;
      ST_CHECK:   nxt_state = bus.stk_empty ? ST_DONE : ST_PRESENT;
      ST_PRESENT: if (handshake) nxt_state = ST_POP;
      ST_POP:     nxt_state = ST_SETTLE;
      ST_DONE:    nxt_state = ST_IDLE;
      default:    nxt_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; Top is only looked at when Empty is low.
  always_comb begin
    nxt_settle = settle_cnt;
    nxt_pop    = 1'b0;
    nxt_valid  = bus.out_valid;
    nxt_dir    = bus.out_dir;
    nxt_hold   = hold;
    nxt_done   = 1'b0;
    nxt_count  = count;
    case (state)
      ST_IDLE: begin
        if (start) begin
          nxt_settle = SETTLE_LOAD;
          nxt_count  = '0;
          nxt_hold   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt != '0) nxt_settle = settle_cnt - 1'b1;
      end
      ST_CHECK: begin
        if (bus.stk_empty) begin
          nxt_done = 1'b1;
        end else begin
          nxt_dir   = INVERT ? opposite(bus.stk_top) : bus.stk_top;
          nxt_valid = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (handshake) begin
          nxt_valid = 1'b0;
          nxt_pop   = 1'b1;
          nxt_count = count + 1'b1;
        end
      end
      ST_POP: begin
        nxt_settle = SETTLE_LOAD;
      end
      ST_DONE: begin
        nxt_hold = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/path_drain.md
Name: path_drain

Overview:
- Downstream consumer of the 2-bit direction stack (256 entries).
- On `start`, pops every stored entry, newest first, and streams each one as a valid/ready move.
- Each move is optionally inverted, so a recorded path becomes its backtrack path for the movement/replay logic.
- Owns the stack's Pop line and raises `hold` so upstream logic gates Push while draining.

Parameters:
- INVERT, 1: 1 = output the opposite direction (dir XOR 2'b10, encoding 0=up 1=right 2=down 3=left); 0 = pass through.
- SETTLE_CYC, 2: wait cycles after any Push/Pop before sampling the stack. The stack's Top and Empty are registered and reflect a Push/Pop two edges later. Must be >= 2.
- CNT_W, 9: width of the drained-entry counter. Holds 0..256.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin draining; ignored unless idle.
- stk_empty  in  1  stack Empty flag.
- stk_top  in  2  stack Top value; X when the stack is empty.
- stk_pop  out  1  Pop strobe to the stack.
- out_valid  out  1  a move is presented.
- out_ready  in  1  consumer accepts the move.
- out_dir  out  2  presented move, inverted per INVERT.
- hold  out  1  high from start acceptance until return to IDLE; upstream must not Push.
- done  out  1  one-cycle pulse when the stack is observed empty.
- count  out  CNT_W  number of moves accepted in the current or most recent drain.

Behaviour:
- Reset values: state=IDLE, stk_pop=0, out_valid=0, out_dir=0, hold=0, done=0, count=0, settle counter=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, SETTLE, CHECK, PRESENT, POP, DONE.
- IDLE:
  - start=1 -> SETTLE; load settle counter with SETTLE_CYC-1; count<=0; hold<=1.
  - start=0 -> stay.
- SETTLE: decrement counter; at 0 -> CHECK. This also covers a Push made the cycle before start.
- CHECK:
  - stk_empty=1 -> DONE.
  - Otherwise out_dir <= INVERT ? stk_top^2'b10 : stk_top; out_valid<=1; -> PRESENT.
  - stk_top is sampled only when stk_empty=0, so X never reaches out_dir.
- PRESENT:
  - out_valid and out_dir are held stable until out_ready=1.
  - On the handshake cycle (out_valid&out_ready): out_valid<=0; stk_pop<=1; count<=count+1; -> POP.
- POP:
  - stk_pop is high for exactly this one cycle, then <=0.
  - Reload the settle counter; -> SETTLE.
- DONE: done<=1 for one cycle; hold<=0; -> IDLE. count holds its value until the next start.
- Throughput: minimum 3+SETTLE_CYC cycles per entry when out_ready is held high (5 at default).
- Entry order is LIFO, matching the stack's pop order.
- Boundary conditions:
  - Empty stack at start: the first CHECK -> DONE with count=0 and no stk_pop pulse.
  - Full stack (256): count reaches 256 without wrap, since CNT_W=9.
  - start while not IDLE: ignored, no restart.
  - out_ready high while out_valid=0: no effect.
  - rst mid-drain: immediate return to reset values. stk_pop drops asynchronously, so no partial pop is issued. Entries already popped are not restored.
- stk_pop is never asserted while the stack reads empty in CHECK.

Decomposition:
- Shared package `path_pkg`:
  - typedef dir_t (2-bit) with constants DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3.
  - function opposite(dir_t).
  - enum drain_state_t.
  - constant STACK_DEPTH=256.
- No sub-module is needed; the FSM plus settle counter is a single module.
- The stack instance is wired at the parent level. The stack's Push is gated with !hold there.

Test Plan:
- Empty drain: reset, start pulse with the stack empty -> done pulses 2+SETTLE_CYC cycles after start (4 at default); count=0; stk_pop never high; out_valid never high.
- Three entries: Push 0,1,3, then start with out_ready=1, INVERT=1:
  - out_dir sequence is 1,3,2.
  - Exactly three one-cycle stk_pop pulses, each 5 cycles apart.
  - count=3, then done; stk_empty=1 after.
- Backpressure: one entry (2), out_ready low for 10 cycles:
  - out_valid=1 and out_dir=0 stay stable.
  - stk_pop stays 0 until out_ready rises, then a single pulse.
- Passthrough and full: INVERT=0, 256 pushes of alternating 0/1, then drain:
  - 256 moves in LIFO order.
  - count=256 (9'h100); Full deasserts after the first pop.
- start while busy: second start mid-drain -> no restart; count keeps incrementing; hold stays high.
- Reset mid-op: assert rst during PRESENT -> out_valid, stk_pop, hold, count all 0 immediately. After release, the block stays IDLE until a new start.
